// File: rtl/aes_job_scheduler_if.sv
// Requester, AES-core and response signals of the AES job scheduler.
// The scheduler takes the slave side; the environment takes the master side.
interface aes_job_scheduler_if;
   logic         req0_valid;
   logic         req1_valid;
   logic         req0_ready;
   logic         req1_ready;
   logic [127:0] req0_plain;
   logic [127:0] req1_plain;
   logic [127:0] req0_key;
   logic [127:0] req1_key;
   logic         core_valid_in;
   logic [127:0] core_plain_text_128;
   logic [127:0] core_cipher_key_128;
   logic         core_valid_out;
   logic [127:0] core_cipher_text_128;
   logic         rsp_valid;
   logic         rsp_id;
   logic [127:0] rsp_data;
   logic [4:0]   inflight;
   logic         err_spurious;

   modport master (
      output req0_valid, req1_valid, req0_plain, req1_plain, req0_key, req1_key,
      output core_valid_out, core_cipher_text_128,
      input  req0_ready, req1_ready, core_valid_in, core_plain_text_128, core_cipher_key_128,
      input  rsp_valid, rsp_id, rsp_data, inflight, err_spurious
   );

   modport slave (
      input  req0_valid, req1_valid, req0_plain, req1_plain, req0_key, req1_key,
      input  core_valid_out, core_cipher_text_128,
      output req0_ready, req1_ready, core_valid_in, core_plain_text_128, core_cipher_key_128,
      output rsp_valid, rsp_id, rsp_data, inflight, err_spurious
   );
endinterface

// File: rtl/aes_job_scheduler.sv
// Round-robin front end for a pipelined AES core: tags each accepted job with its
// requester in an in-order FIFO and routes the core's in-order results back.
module aes_job_scheduler #(
   parameter int MAX_INFLIGHT = 4
) (
   input logic                clk,
   input logic                reset,
   aes_job_scheduler_if.slave sched_if
);
   localparam int              PW       = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam logic [4:0]      CNT_MAX  = 5'(MAX_INFLIGHT);
   localparam logic [PW-1:0]   PTR_LAST = PW'(MAX_INFLIGHT - 1);

   logic          armed_q, armed_d;
   logic          prio_q, prio_d;
   logic [4:0]    inflight_q, inflight_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          tag_mem_q [MAX_INFLIGHT];
   logic          err_q, err_d;
   logic          core_vld_q, core_vld_d;
   logic [127:0]  core_plain_q, core_plain_d;
   logic [127:0]  core_key_q, core_key_d;
   logic          rsp_vld_q, rsp_vld_d;
   logic          rsp_id_q, rsp_id_d;
   logic [127:0]  rsp_data_q, rsp_data_d;

   logic          can_accept, rdy0, rdy1, accept, grant_id, pop;

   // Full is decided from the registered count, so a same-cycle pop never frees a slot early.
   always_comb begin
      can_accept = armed_q && (inflight_q != CNT_MAX);
      rdy0       = can_accept && sched_if.req0_valid && (!sched_if.req1_valid || !prio_q);
      rdy1       = can_accept && sched_if.req1_valid && (!sched_if.req0_valid || prio_q);
      accept     = rdy0 | rdy1;
      grant_id   = rdy1;
      pop        = sched_if.core_valid_out && (inflight_q != 5'd0);
   end

   always_comb begin
      armed_d      = 1'b1;
      prio_d       = prio_q;
      inflight_d   = inflight_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      err_d        = err_q;
      core_vld_d   = accept;
      core_plain_d = core_plain_q;
      core_key_d   = core_key_q;
      rsp_vld_d    = pop;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;

      if (accept) begin
         prio_d       = ~grant_id;
         wr_ptr_d     = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         core_plain_d = grant_id ? sched_if.req1_plain : sched_if.req0_plain;
         core_key_d   = grant_id ? sched_if.req1_key   : sched_if.req0_key;
      end

      if (pop) begin
         rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         rsp_id_d   = tag_mem_q[rd_ptr_q];
         rsp_data_d = sched_if.core_cipher_text_128;
      end

      if (sched_if.core_valid_out && (inflight_q == 5'd0)) err_d = 1'b1;

      case ({accept, pop})
         2'b10:   inflight_d = inflight_q + 5'd1;
         2'b01:   inflight_d = inflight_q - 5'd1;
         default: inflight_d = inflight_q;
      endcase
   end

   // armed_q holds off acceptance for the first cycle after reset is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed_q      <= 1'b0;
         prio_q       <= 1'b0;
         inflight_q   <= 5'd0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         err_q        <= 1'b0;
         core_vld_q   <= 1'b0;
         core_plain_q <= '0;
         core_key_q   <= '0;
         rsp_vld_q    <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         armed_q      <= armed_d;
         prio_q       <= prio_d;
         inflight_q   <= inflight_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         err_q        <= err_d;
         core_vld_q   <= core_vld_d;
         core_plain_q <= core_plain_d;
         core_key_q   <= core_key_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   // Tag storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (accept) tag_mem_q[wr_ptr_q] <= grant_id;
   end

   assign sched_if.req0_ready          = rdy0;
   assign sched_if.req1_ready          = rdy1;
   assign sched_if.core_valid_in       = core_vld_q;
   assign sched_if.core_plain_text_128 = core_plain_q;
   assign sched_if.core_cipher_key_128 = core_key_q;
   assign sched_if.rsp_valid           = rsp_vld_q;
   assign sched_if.rsp_id              = rsp_id_q;
   assign sched_if.rsp_data            = rsp_data_q;
   assign sched_if.inflight            = inflight_q;
   assign sched_if.err_spurious        = err_q;
endmodule

// File: tb/tb_aes_job_scheduler.sv
// Randomized scoreboard bench for aes_job_scheduler with a fake in-order AES core
// and a transaction-level reference model of arbitration, tagging and counting.
module tb_aes_job_scheduler;
   localparam int           MAXI    = 4;
   localparam logic [127:0] VEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   typedef struct { int due; logic [127:0] plain; logic [127:0] key; } core_exp_t;
   typedef struct { int due; logic id; logic [127:0] data; } rsp_exp_t;
   typedef struct { int due; logic [127:0] data; } fc_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   aes_job_scheduler_if bus();

   aes_job_scheduler #(.MAX_INFLIGHT(MAXI)) dut (
      .clk      (clk),
      .reset    (reset),
      .sched_if (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   core_exp_t exp_core[$];
   rsp_exp_t  exp_rsp[$];
   fc_t       fc_q[$];
   logic      tagq[$];
   int        rid_log[$];

   int           m_count = 0;
   bit           m_prio = 0, m_armed = 0, m_err = 0;
   logic [127:0] m_last_plain = '0, m_last_key = '0;
   int           m_acc_total = 0, ev_acc_pop3 = 0, ev_full_pop = 0, d_max = 0;
   bit           s_rdy0 = 0, s_rdy1 = 0;
   logic [127:0] lc_plain = '0, lc_key = '0, lr_data = '0;
   logic         lr_id = 1'b0;
   int           lc_cnt = 0, lr_cnt = 0, fc_last_due = 0;
   int           lat = 5, mode = 0;
   bit           force_vec = 0, single_pending = 0, inject_spur = 0, log_rid = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor + reference model: compare what the DUT shows now, then predict the next edge.
   always @(negedge clk) begin
      core_exp_t ce;
      rsp_exp_t  re;
      fc_t       f;
      bit        ok, e0, e1, acc, popm;
      if (reset) begin
         chk("rst_core_valid_in", bus.core_valid_in, 0);
         chk("rst_rsp_valid", bus.rsp_valid, 0);
         chk("rst_req0_ready", bus.req0_ready, 0);
         chk("rst_req1_ready", bus.req1_ready, 0);
         chk("rst_inflight", bus.inflight, 0);
         chk("rst_err", bus.err_spurious, 0);
         chk("rst_rsp_data", {bus.rsp_id, bus.rsp_data}, 0);
         chk("rst_core_ops", bus.core_plain_text_128 | bus.core_cipher_key_128, 0);
         m_count = 0; m_prio = 0; m_armed = 0; m_err = 0;
         m_last_plain = '0; m_last_key = '0;
         exp_core.delete(); exp_rsp.delete(); tagq.delete();
         s_rdy0 = 0; s_rdy1 = 0;
      end else begin
         if (bus.core_valid_in) begin
            if (exp_core.size() == 0) chk("core_issue_unexpected", 1, 0);
            else begin
               ce = exp_core.pop_front();
               chk("core_issue_cycle", cyc, ce.due);
               chk("core_plain", bus.core_plain_text_128, ce.plain);
               chk("core_key", bus.core_cipher_key_128, ce.key);
               m_last_plain = ce.plain; m_last_key = ce.key;
            end
            lc_plain = bus.core_plain_text_128; lc_key = bus.core_cipher_key_128; lc_cnt++;
            f.due = (cyc + lat > fc_last_due) ? cyc + lat : fc_last_due + 1;
            fc_last_due = f.due;
            f.data = force_vec ? VEC_CT : (bus.core_plain_text_128 ^ ~bus.core_cipher_key_128);
            fc_q.push_back(f);
         end else begin
            if (exp_core.size() > 0 && exp_core[0].due <= cyc) begin
               chk("core_issue_missing", 0, 1);
               void'(exp_core.pop_front());
            end
            chk("core_ops_hold", {bus.core_plain_text_128, bus.core_cipher_key_128} == {m_last_plain, m_last_key}, 1);
         end

         if (bus.rsp_valid) begin
            if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
               re = exp_rsp.pop_front();
               chk("rsp_cycle", cyc, re.due);
               chk("rsp_id", bus.rsp_id, re.id);
               chk("rsp_data", bus.rsp_data, re.data);
            end
            lr_id = bus.rsp_id; lr_data = bus.rsp_data; lr_cnt++;
            if (log_rid) rid_log.push_back(int'(bus.rsp_id));
         end else if (exp_rsp.size() > 0 && exp_rsp[0].due <= cyc) begin
            chk("rsp_missing", 0, 1);
            void'(exp_rsp.pop_front());
         end

         chk("inflight", bus.inflight, m_count);
         chk("err_spurious", bus.err_spurious, m_err);
         if (int'(bus.inflight) > d_max) d_max = int'(bus.inflight);

         ok = m_armed && (m_count < MAXI);
         e0 = ok && bus.req0_valid && (!bus.req1_valid || m_prio == 0);
         e1 = ok && bus.req1_valid && (!bus.req0_valid || m_prio == 1);
         chk("req0_ready", bus.req0_ready, e0);
         chk("req1_ready", bus.req1_ready, e1);
         s_rdy0 = bus.req0_ready; s_rdy1 = bus.req1_ready;
         acc  = e0 || e1;
         popm = bus.core_valid_out && (m_count > 0);
         if (acc) begin
            ce.due   = cyc + 1;
            ce.plain = e1 ? bus.req1_plain : bus.req0_plain;
            ce.key   = e1 ? bus.req1_key : bus.req0_key;
            exp_core.push_back(ce);
            tagq.push_back(e1);
            m_prio = e0;
            m_acc_total++;
         end
         if (bus.core_valid_out) begin
            if (m_count > 0) begin
               re.due = cyc + 1; re.id = tagq.pop_front(); re.data = bus.core_cipher_text_128;
               exp_rsp.push_back(re);
            end else m_err = 1;
         end
         if (acc && popm && m_count == MAXI - 1) ev_acc_pop3++;
         if (popm && m_count == MAXI) ev_full_pop++;
         m_count = m_count + int'(acc) - int'(popm);
         m_armed = 1;
      end
   end

   task automatic fake_core();
      fc_t f;
      forever begin
         @(posedge clk); #1;
         if (fc_q.size() > 0 && fc_q[0].due <= cyc) begin
            f = fc_q.pop_front();
            bus.core_valid_out = 1'b1; bus.core_cipher_text_128 = f.data;
         end else if (inject_spur) begin
            inject_spur = 0;
            bus.core_valid_out = 1'b1;
            bus.core_cipher_text_128 = {$urandom, $urandom, $urandom, $urandom};
         end else bus.core_valid_out = 1'b0;
      end
   endtask

   task automatic requesters();
      forever begin
         @(posedge clk); #1;
         case (mode)
            1: begin
               if (!bus.req0_valid || s_rdy0) begin
                  bus.req0_plain = {$urandom, $urandom, $urandom, $urandom};
                  bus.req0_key   = {$urandom, $urandom, $urandom, $urandom};
               end
               if (!bus.req1_valid || s_rdy1) begin
                  bus.req1_plain = {$urandom, $urandom, $urandom, $urandom};
                  bus.req1_key   = {$urandom, $urandom, $urandom, $urandom};
               end
               bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
            end
            2: begin
               lat = int'($urandom_range(12, 1));
               if ((bus.req0_valid && s_rdy0) || !bus.req0_valid) begin
                  bus.req0_valid = ($urandom_range(2) != 0);
                  bus.req0_plain = {$urandom, $urandom, $urandom, $urandom};
                  bus.req0_key   = {$urandom, $urandom, $urandom, $urandom};
               end
               if ((bus.req1_valid && s_rdy1) || !bus.req1_valid) begin
                  bus.req1_valid = ($urandom_range(2) != 0);
                  bus.req1_plain = {$urandom, $urandom, $urandom, $urandom};
                  bus.req1_key   = {$urandom, $urandom, $urandom, $urandom};
               end
            end
            3: begin
               bus.req1_valid = 1'b0;
               if (bus.req0_valid && s_rdy0) bus.req0_valid = 1'b0;
               else if (single_pending) begin
                  single_pending = 0;
                  bus.req0_plain = VEC_PT; bus.req0_key = VEC_KEY; bus.req0_valid = 1'b1;
               end
            end
            default: begin
               bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            end
         endcase
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (!(m_count == 0 && fc_q.size() == 0 && exp_rsp.size() == 0 && !bus.req0_valid && !bus.req1_valid) && n < budget) begin
         @(negedge clk); n++;
      end
      chk({name, "_idle_timeout"}, n < budget, 1);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      chk("async_core_valid_in", bus.core_valid_in, 0);
      chk("async_rsp_valid", bus.rsp_valid, 0);
      chk("async_ready", {bus.req0_ready, bus.req1_ready}, 0);
      chk("async_inflight", bus.inflight, 0);
      chk("async_err", bus.err_spurious, 0);
      chk("async_rsp", {bus.rsp_id, bus.rsp_data}, 0);
      chk("async_core_ops", {bus.core_plain_text_128, bus.core_cipher_key_128}, 0);
      mode = 0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      int n, c0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_plain = '0; bus.req1_plain = '0; bus.req0_key = '0; bus.req1_key = '0;
      bus.core_valid_out = 1'b0; bus.core_cipher_text_128 = '0;
      fork
         fake_core();
         requesters();
      join_none

      // Single known-answer job, requested while reset is still high.
      force_vec = 1; lat = 5; mode = 3; single_pending = 1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("first_cycle_no_ready", bus.req0_ready, 0);
      @(negedge clk);
      chk("second_cycle_ready", bus.req0_ready, 1);
      n = 0;
      while (lr_cnt == 0 && n < 40) begin @(negedge clk); n++; end
      chk("single_rsp_timeout", n < 40, 1);
      chk("single_rsp_data", lr_data, VEC_CT);
      chk("single_rsp_id", lr_id, 0);
      chk("single_core_plain", lc_plain, VEC_PT);
      chk("single_core_key", lc_key, VEC_KEY);
      mode = 0; force_vec = 0;
      wait_idle("single", 50);

      // Continuous contention, core latency 10.
      @(posedge clk); #3;
      pulse_reset();
      lat = 10; rid_log.delete(); log_rid = 1; d_max = 0; mode = 1;
      repeat (60) @(negedge clk);
      mode = 0;
      wait_idle("contention", 100);
      log_rid = 0;
      chk("contention_rsp_count", rid_log.size() >= 8, 1);
      for (int i = 0; i < 8 && i < rid_log.size(); i++)
         chk($sformatf("contention_rid%0d", i), rid_log[i], i % 2);
      chk("contention_max_inflight", d_max, MAXI);
      chk("accept_and_pop_at_3_seen", ev_acc_pop3 > 0, 1);
      chk("pop_at_full_seen", ev_full_pop > 0, 1);

      // Spurious core result with nothing in flight.
      c0 = lr_cnt;
      inject_spur = 1;
      repeat (3) @(negedge clk);
      chk("spur_err_set", bus.err_spurious, 1);
      chk("spur_no_rsp", lr_cnt, c0);
      chk("spur_inflight", bus.inflight, 0);
      repeat (10) @(negedge clk);
      chk("spur_err_sticky", bus.err_spurious, 1);

      // Reset with three jobs in flight, stale results afterwards, then wrap traffic.
      lat = 10; mode = 1; n = 0;
      @(negedge clk);
      while (bus.inflight != 5'd3 && n < 40) begin @(negedge clk); n++; end
      chk("reach_inflight3_timeout", n < 40, 1);
      #1;
      pulse_reset();
      c0 = lr_cnt; n = 0;
      while (fc_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
      chk("stale_drain_timeout", n < 60, 1);
      repeat (2) @(negedge clk);
      chk("stale_err_set", bus.err_spurious, 1);
      chk("stale_no_rsp", lr_cnt, c0);
      m_acc_total = 0; mode = 2; n = 0;
      while (m_acc_total < 20 && n < 2000) begin @(negedge clk); n++; end
      chk("wrap_jobs_timeout", n < 2000, 1);
      mode = 0;
      wait_idle("wrap", 200);
      chk("wrap_rsp_count", lr_cnt - c0, m_acc_total);
      chk("wrap_err_still_set", bus.err_spurious, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/aes_job_scheduler.md
AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of jobs accepted but not yet returned by the AES core (range 1..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N has a job pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester N's job is accepted this cycle.
REQ-006 SHALL have ports req0_plain / req1_plain  input  128  plaintext block from requester N.
REQ-007 SHALL have ports req0_key / req1_key  input  128  cipher key from requester N.
REQ-008 SHALL have port core_valid_in  output  1  one-cycle job strobe to the AES core.
REQ-009 SHALL have ports core_plain_text_128 / core_cipher_key_128  output  128 each  job operands to the core.
REQ-010 SHALL have port core_valid_out  input  1  core result strobe.
REQ-011 SHALL have port core_cipher_text_128  input  128  core result data.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle result strobe to requesters; no backpressure.
REQ-013 SHALL have port rsp_id  output  1  requester that owns the result.
REQ-014 SHALL have port rsp_data  output  128  ciphertext.
REQ-015 SHALL have port inflight  output  5  current in-flight job count.
REQ-016 SHALL have port err_spurious  output  1  sticky flag, set by core_valid_out with no job in flight.

Function
REQ-017 SHALL accept a job from requester N on any cycle where reqN_valid and reqN_ready are both 1.
REQ-018 SHALL drive reqN_ready combinationally; at most one ready high per cycle; no ready while inflight == MAX_INFLIGHT.
REQ-019 SHALL arbitrate round-robin: priority pointer resets to 0; when both requesters are valid, grant the pointed-to requester; after any grant, point to the other requester; a lone valid requester is granted regardless of the pointer.
REQ-020 SHALL, for an acceptance at cycle T, drive core_valid_in = 1 at T+1 for exactly one cycle, with the accepted plain/key registered on the core operand outputs.
REQ-021 SHALL hold core operand outputs at their last values when core_valid_in = 0.
REQ-022 SHALL push the granted requester id into an in-order tag FIFO of depth MAX_INFLIGHT on acceptance.
REQ-023 SHALL treat core results as strictly in issue order.
REQ-024 SHALL, for core_valid_out = 1 at cycle C with inflight > 0, pop the tag FIFO and drive rsp_valid = 1, rsp_id = popped tag, rsp_data = core_cipher_text_128 (registered) at C+1.
REQ-025 SHALL, for core_valid_out = 1 with inflight == 0, suppress rsp_valid, leave the FIFO and count unchanged, and set err_spurious until reset.
REQ-026 SHALL increment inflight on acceptance and decrement it on a valid pop; when both occur in the same cycle, inflight is unchanged.
REQ-027 SHALL permit acceptance at inflight == MAX_INFLIGHT-1 even with a simultaneous pop, and SHALL NOT accept at MAX_INFLIGHT even with a simultaneous pop (registered full decision).
REQ-028 SHALL wrap FIFO read/write pointers modulo MAX_INFLIGHT.
REQ-029 SHALL sustain one acceptance per cycle while not full.

Reset
REQ-030 SHALL, while reset = 1, immediately force core_valid_in = 0, rsp_valid = 0, req0_ready = req1_ready = 0, inflight = 0, err_spurious = 0, rsp_id = 0, rsp_data = 0, core operands = 0, FIFO pointers = 0, and priority pointer = 0.
REQ-031 SHALL discard all in-flight tags on reset mid-operation; core results arriving after reset deassertion are treated per REQ-025.
REQ-032 SHALL accept no job in the first cycle after reset deassertion, and accept normally from the second cycle.

Verification
REQ-033 Single job: req0 key 000102030405060708090a0b0c0d0e0f, plain 00112233445566778899aabbccddeeff -> core_valid_in one cycle later with those operands; core returns 69c4e0d86a7b0430d8cdb78070b4c55a -> rsp_valid next cycle, rsp_id = 0, same data.
REQ-034 Contention: req0 and req1 valid continuously, MAX_INFLIGHT = 4, core latency 10 -> grants alternate 0,1,0,1; ready drops at inflight = 4; rsp_id sequence 0,1,0,1.
REQ-035 Simultaneous accept and pop at inflight = 3 -> inflight stays 3; at inflight = 4 with pop -> no accept that cycle, inflight = 3 next.
REQ-036 Spurious core_valid_out with inflight = 0 -> no rsp_valid; err_spurious = 1 and held until reset.
REQ-037 Reset asserted with 3 jobs in flight -> outputs zero asynchronously; core results arriving afterward set err_spurious; FIFO wraps correctly over 20 subsequent jobs.
